microwave_timer_countdown: RTL and testbench

MICROWAVE_TIMER_COUNTDOWN -- requirements
Module: microwave_timer_countdown

---
 rtl/microwave_timer_countdown_pkg.sv | 21 ++
 rtl/bcd_down_digit.sv | 32 +++
 rtl/microwave_timer_countdown.sv | 138 +++++++++++++
 tb/tb_microwave_timer_countdown.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/microwave_timer_countdown_pkg.sv
// Shared types and constants for the microwave countdown timer.
package microwave_timer_countdown_pkg;

  localparam int         BCD_W             = 4;
  localparam logic [3:0] BCD_MAX           = 4'd9;
  localparam int         SEC_TENS_MAX_DFLT = 5;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True when a keypad code is a legal decimal digit.
  function automatic logic is_bcd(input bcd_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with a parallel shift-in port and borrow-out.
module bcd_down_digit
  import microwave_timer_countdown_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_shift,
  input  bcd_t i_shift_val,
  input  logic i_dec,
  input  bcd_t i_reload,
  output bcd_t o_digit,
  output logic o_borrow
);

  bcd_t r_digit;

  // Shift-in wins over decrement; the top never requests both in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit <= '0;
    end else if (i_shift) begin
      r_digit <= i_shift_val;
    end else if (i_dec) begin
      r_digit <= (r_digit == '0) ? i_reload : (r_digit - 1'b1);
    end
  end

  assign o_digit  = r_digit;
  // A decrement of a zero digit wraps it and takes one from the next digit up.
  assign o_borrow = i_dec && (r_digit == '0);

endmodule

// File: rtl/microwave_timer_countdown.sv
// M:SS countdown timer: keypad digits shift in while idle, 1 Hz ticks count
// down while running, and a one-clock done pulse marks arrival at 0:00.
//
// Handshake: the encoder has no ready; a load is the falling edge of loadn and
// a tick is the rising edge of pgt_1Hz, each detected against a one-clock
// registered copy. Events arriving in a state that does not use them are lost.
module microwave_timer_countdown
  import microwave_timer_countdown_pkg::*;
#(
  parameter int SEC_TENS_MAX = SEC_TENS_MAX_DFLT
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       enablen,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic       zero,
  output logic       done,
  output state_t     o_dbg_state
);

  localparam bcd_t TENS_RELOAD = BCD_W'(SEC_TENS_MAX);

  state_t r_state;
  logic   r_done;
  logic   r_loadn_q;
  logic   r_pgt_q;

  logic   w_load_evt;
  logic   w_tick;
  logic   w_shift;
  logic   w_dec;
  logic   w_will_zero;
  logic   w_ones_borrow;
  logic   w_tens_borrow;
  logic   w_min_borrow_unused;
  bcd_t   w_sec_ones;
  bcd_t   w_sec_tens;
  bcd_t   w_min_ones;

  // Edge-detect registers reset to the idle levels so release needs a fresh edge.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      r_loadn_q <= 1'b1;
      r_pgt_q   <= 1'b0;
    end else begin
      r_loadn_q <= loadn;
      r_pgt_q   <= pgt_1Hz;
    end
  end

  assign w_load_evt = r_loadn_q && !loadn;
  assign w_tick     = !r_pgt_q && pgt_1Hz;

  assign zero = (w_sec_ones == '0) && (w_sec_tens == '0) && (w_min_ones == '0);

  // Shift only legal digits, and only while programming.
  assign w_shift = (r_state == ST_IDLE) && w_load_evt && is_bcd(D);

  // A pause in the same cycle as a tick suppresses the decrement; the zero
  // gate keeps the value from ever wrapping below 0:00.
  assign w_dec = (r_state == ST_RUN) && w_tick && !enablen && !zero;

  // 0:01 is the only value whose next second is 0:00.
  assign w_will_zero = w_dec && (w_min_ones == '0) && (w_sec_tens == '0) &&
                       (w_sec_ones == bcd_t'(1));

  bcd_down_digit u_sec_ones (
    .clk         (clk),
    .rst_n       (clearn),
    .i_shift     (w_shift),
    .i_shift_val (D),
    .i_dec       (w_dec),
    .i_reload    (BCD_MAX),
    .o_digit     (w_sec_ones),
    .o_borrow    (w_ones_borrow)
  );

  bcd_down_digit u_sec_tens (
    .clk         (clk),
    .rst_n       (clearn),
    .i_shift     (w_shift),
    .i_shift_val (w_sec_ones),
    .i_dec       (w_ones_borrow),
    .i_reload    (TENS_RELOAD),
    .o_digit     (w_sec_tens),
    .o_borrow    (w_tens_borrow)
  );

  bcd_down_digit u_min_ones (
    .clk         (clk),
    .rst_n       (clearn),
    .i_shift     (w_shift),
    .i_shift_val (w_sec_tens),
    .i_dec       (w_tens_borrow),
    .i_reload    (BCD_MAX),
    .o_digit     (w_min_ones),
    .o_borrow    (w_min_borrow_unused)
  );

  // Control FSM: programming, counting, and holding at 0:00 until disabled.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!enablen && !zero) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (enablen) begin
            r_state <= ST_IDLE;
          end else if (w_will_zero) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (enablen) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sec_ones    = w_sec_ones;
  assign sec_tens    = w_sec_tens;
  assign min_ones    = w_min_ones;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_microwave_timer_countdown.sv
// Directed bench for the microwave countdown timer.
module tb_microwave_timer_countdown;
  import microwave_timer_countdown_pkg::*;

  logic       clk = 1'b0;
  logic       clearn;
  logic [3:0] D;
  logic       loadn;
  logic       pgt_1Hz;
  logic       enablen;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic       zero;
  logic       done;
  state_t     dbg_state;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int done_base;

  microwave_timer_countdown #(.SEC_TENS_MAX(5)) dut (
    .clk         (clk),
    .clearn      (clearn),
    .D           (D),
    .loadn       (loadn),
    .pgt_1Hz     (pgt_1Hz),
    .enablen     (enablen),
    .sec_ones    (sec_ones),
    .sec_tens    (sec_tens),
    .min_ones    (min_ones),
    .zero        (zero),
    .done        (done),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Counts every clock in which done is high, sampled mid-cycle.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [11:0] exp);
    chk(tag, {20'h0, min_ones, sec_tens, sec_ones}, {20'h0, exp});
  endtask

  task automatic do_reset();
    clearn  = 1'b0;
    D       = 4'd0;
    loadn   = 1'b1;
    pgt_1Hz = 1'b0;
    enablen = 1'b1;
    repeat (3) @(posedge clk);
    #1 clearn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    @(posedge clk); #1;
    D = d; loadn = 1'b0;
    repeat (2) @(posedge clk); #1;
    loadn = 1'b1;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    pgt_1Hz = 1'b1;
    repeat (2) @(posedge clk); #1;
    pgt_1Hz = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic set_en(input logic v);
    @(posedge clk); #1;
    enablen = v;
    repeat (2) @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_val("reset_digits", 12'h000);
    chk("reset_zero", zero, 1);
    chk("reset_done", done, 0);
    chk("reset_state", dbg_state, ST_IDLE);

    // Keys 1,3,0
    key(4'd1); key(4'd3); key(4'd0);
    chk_val("keys_130", 12'h130);
    chk("keys_130_zero", zero, 0);

    // No start on an empty timer
    do_reset();
    set_en(1'b0);
    chk("empty_no_start", dbg_state, ST_IDLE);
    set_en(1'b1);

    // 0:01 -> one tick -> 0:00 with one done pulse
    key(4'd0); key(4'd1);
    chk_val("load_001", 12'h001);
    set_en(1'b0);
    chk("run_state", dbg_state, ST_RUN);
    done_base = done_cnt;
    tick();
    chk_val("tick_to_000", 12'h000);
    chk("done_one_pulse", done_cnt - done_base, 1);
    chk("done_low_after", done, 0);
    chk("state_done", dbg_state, ST_DONE);
    tick();
    chk_val("done_tick_ignored", 12'h000);
    chk("done_no_second_pulse", done_cnt - done_base, 1);
    set_en(1'b1);
    chk("done_to_idle", dbg_state, ST_IDLE);

    // 1:00 -> 0:59 -> ... -> 0:00
    key(4'd1); key(4'd0); key(4'd0);
    chk_val("load_100", 12'h100);
    set_en(1'b0);
    done_base = done_cnt;
    tick();
    chk_val("borrow_059", 12'h059);
    repeat (58) tick();
    chk_val("count_001", 12'h001);
    chk("no_early_done", done_cnt - done_base, 0);
    tick();
    chk_val("count_000", 12'h000);
    chk("done_after_60", done_cnt - done_base, 1);
    set_en(1'b1);

    // Four keys keep last three; illegal digit and running loads ignored
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    chk_val("keys_234", 12'h234);
    key(4'd12);
    chk_val("bad_digit_ignored", 12'h234);
    set_en(1'b0);
    key(4'd7);
    chk_val("run_load_ignored", 12'h234);
    chk("run_load_state", dbg_state, ST_RUN);
    set_en(1'b1);

    // 0:10, 3 ticks, pause, idle ticks ignored, resume
    key(4'd0); key(4'd1); key(4'd0);
    chk_val("load_010", 12'h010);
    set_en(1'b0);
    repeat (3) tick();
    chk_val("count_007", 12'h007);
    set_en(1'b1);
    chk("pause_state", dbg_state, ST_IDLE);
    repeat (2) tick();
    chk_val("idle_ticks_ignored", 12'h007);
    set_en(1'b0);
    tick();
    chk_val("resume_006", 12'h006);

    // Tick coinciding with pause is dropped
    @(posedge clk); #1;
    enablen = 1'b1; pgt_1Hz = 1'b1;
    repeat (2) @(posedge clk); #1;
    pgt_1Hz = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk_val("pause_priority", 12'h006);
    chk("pause_priority_state", dbg_state, ST_IDLE);

    // Oversized seconds-tens counts down uncorrected: 6:95 -> 6:89
    key(4'd9); key(4'd5);
    chk_val("load_695", 12'h695);
    set_en(1'b0);
    repeat (6) tick();
    chk_val("count_689", 12'h689);
    set_en(1'b1);

    // Asynchronous reset mid-count at 0:45
    do_reset();
    key(4'd5); key(4'd0);
    set_en(1'b0);
    repeat (5) tick();
    chk_val("count_045", 12'h045);
    done_base = done_cnt;
    @(posedge clk); #3;
    clearn = 1'b0;
    #1;
    chk_val("async_clear_digits", 12'h000);
    chk("async_clear_zero", zero, 1);
    chk("async_clear_state", dbg_state, ST_IDLE);
    repeat (2) @(posedge clk); #1;
    enablen = 1'b1;
    clearn  = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("async_no_done", done_cnt - done_base, 0);
    chk_val("async_after_release", 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
